// File: rtl/dff_pipe.sv
// Elastic WIDTH-bit register pipeline of DEPTH stages with valid/ready on both sides.
// Define DFF_PIPE_COUNT_EN to add the registered occupancy output count_o.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic             flush_i
`ifdef DFF_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`endif
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic             accept;

  // A stage advances when its successor is empty or itself advancing; empty stages
  // always load, which is what closes bubbles while the output is stalled.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = vld_q[DEPTH-1] & ready_i;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = vld_q[k] & (~vld_q[k+1] | adv[k+1]);
    end
    load = ~vld_q | adv;
  end

  assign ready_o = load[0];
  assign valid_o = vld_q[DEPTH-1];
  assign q_o     = data_q[DEPTH-1];
  assign accept  = valid_i & ready_o;

  // Stage valid bits: flush wins over any simultaneous accept or advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else begin
      if (load[0]) vld_q[0] <= valid_i;
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) vld_q[k] <= adv[k-1];
      end
    end
  end

  // Stage data moves only on a real transfer, so q_o holds while stalled or empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= RST_VAL;
    end else if (!flush_i) begin
      if (accept) data_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

`ifdef DFF_PIPE_COUNT_EN
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_q;
  logic             out_xfer;

  assign out_xfer = valid_o & ready_i;
  assign count_o  = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else if (accept && !out_xfer) begin
      count_q <= count_q + CNT_W'(1);
    end else if (!accept && out_xfer) begin
      count_q <= count_q - CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=4, RST_VAL=0).
module tb_dff_pipe;

  logic       clk;
  logic       reset;
  logic [7:0] d_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] q_o;
  logic       valid_o;
  logic       ready_i;
  logic       flush_i;
`ifdef DFF_PIPE_COUNT_EN
  logic [2:0] count_o;
`endif

  int checks = 0;
  int errors = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
    .clk     (clk),
    .reset   (reset),
    .d_i     (d_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .q_o     (q_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .flush_i (flush_i)
`ifdef DFF_PIPE_COUNT_EN
    ,
    .count_o (count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag, input int exp);
`ifdef DFF_PIPE_COUNT_EN
    check(tag, 32'(count_o), 32'(exp));
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  logic [7:0] stream_w [4];
  logic [7:0] got_w    [8];
  int         ptr;
  int         n;
  logic       acc;
  logic       exp_v;

  initial begin
    stream_w = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset held for two cycles with random inputs
    reset   = 1'b0;
    d_i     = 8'($urandom);
    valid_i = 1'($urandom);
    ready_i = 1'($urandom);
    flush_i = 1'($urandom);
    tick();
    tick();
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_q_o",     32'(q_o),     32'h00);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    check_count("rst_count", 0);
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    d_i     = 8'h00;
    reset   = 1'b1;
    tick();

    // Stream: four words back to back, out in cycles 4..7
    for (int i = 0; i < 10; i++) begin
      valid_i = (i < 4);
      d_i     = (i < 4) ? stream_w[i] : 8'h00;
      tick();
      exp_v = (i + 1 >= 4) && (i + 1 <= 7);
      check($sformatf("stream_valid_c%0d", i + 1), 32'(valid_o), 32'(exp_v));
      if (exp_v) check($sformatf("stream_q_c%0d", i + 1), 32'(q_o), 32'(stream_w[i-3]));
    end
    valid_i = 1'b0;

    // Fill under backpressure: only A0..A3 get in
    ready_i = 1'b0;
    ptr = 0;
    for (int c = 0; c < 8; c++) begin
      valid_i = 1'b1;
      d_i     = 8'hA0 + 8'(ptr);
      #1;
      check($sformatf("fill_ready_c%0d", c), 32'(ready_o), 32'(c < 4));
      acc = valid_i & ready_o;
      tick();
      if (acc) ptr++;
    end
    check("fill_accepted", 32'(ptr), 32'd4);
    check("fill_valid_o",  32'(valid_o), 32'd1);
    check("fill_q_o",      32'(q_o), 32'hA0);
    check_count("fill_count", 4);

    // Full with ready_i=1: in and out together, ready_o stays up
    ready_i = 1'b1;
    #1;
    check("full_drain_ready_o", 32'(ready_o), 32'd1);
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      valid_i = (ptr < 6);
      d_i     = 8'hA0 + 8'(ptr);
      #1;
      acc = valid_i & ready_o;
      if (valid_o) begin
        got_w[n] = q_o;
        n++;
      end
      tick();
      if (acc) ptr++;
    end
    valid_i = 1'b0;
    check("drain_count_words", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("drain_word%0d", i), 32'(got_w[i]), 32'hA0 + 32'(i));
    tick();
    check("drain_empty", 32'(valid_o), 32'd0);

    // Bubble collapse: 01, two idle cycles, 02, with output stalled
    ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      valid_i = (c == 0) || (c == 3);
      d_i     = (c == 0) ? 8'h01 : 8'h02;
      tick();
    end
    valid_i = 1'b0;
    check("bubble_valid_o", 32'(valid_o), 32'd1);
    check("bubble_q_o",     32'(q_o), 32'h01);
    check("bubble_ready_o", 32'(ready_o), 32'd1);
    check_count("bubble_count", 2);
    ready_i = 1'b1;
    tick();
    check("bubble_second_valid", 32'(valid_o), 32'd1);
    check("bubble_second_q",     32'(q_o), 32'h02);
    tick();
    check("bubble_drained", 32'(valid_o), 32'd0);

    // Flush with three words held and a simultaneous offer of FF
    ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      valid_i = (c < 3);
      d_i     = 8'h31 + 8'(c);
      tick();
    end
    valid_i = 1'b0;
    check_count("preflush_count", 3);
    check("preflush_q_o", 32'(q_o), 32'h31);
    flush_i = 1'b1;
    valid_i = 1'b1;
    d_i     = 8'hFF;
    #1;
    check("flush_ready_o", 32'(ready_o), 32'd1);
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_valid_o", 32'(valid_o), 32'd0);
    check_count("flush_count", 0);
    ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("flush_nothing_out_c%0d", c), 32'(valid_o), 32'd0);
    end

    // Asynchronous reset between edges while full
    ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      valid_i = (c < 4);
      d_i     = 8'h51 + 8'(c);
      tick();
    end
    valid_i = 1'b0;
    check("prereset_valid_o", 32'(valid_o), 32'd1);
    check("prereset_ready_o", 32'(ready_o), 32'd0);
    check("prereset_q_o",     32'(q_o), 32'h51);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_valid_o", 32'(valid_o), 32'd0);
    check("async_rst_q_o",     32'(q_o), 32'h00);
    check("async_rst_ready_o", 32'(ready_o), 32'd1);
    check_count("async_rst_count", 0);
    #2;
    reset = 1'b1;
    tick();
    check("post_rst_valid_o", 32'(valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
